c1_bus_master: RTL and testbench

- Synthesizable, parametrised CPU-side master for the C1 cache bus.
- Turns a single-cycle valid/ready request into the full C1 transaction:
  - two-cycle address phase (tag+set, then offset);
  - tri-state drive and release of the bus;
  - wait for C1_RESPONSE, then collect 8/16/32-bit read data.
- Sits between a CPU/traffic-generator model and the Cache C1 port; replaces hand-written bench sequencing.
- New over the hand-driven flow:
  - configurable widths;
  - response timeout with error reporting;
  - back-to-back request acceptance.

---
 rtl/c1_pkg.sv | 36 +++
 rtl/c1_bus_drv.sv | 17 +
 rtl/c1_bus_master.sv | 148 ++++++++++++++
 tb/tb_c1_bus_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c1_pkg.sv
// Shared types for the C1 cache-bus master: commands, FSM states
// and command-class helpers.
package c1_pkg;

  typedef enum logic [2:0] {
    C1_NOP             = 3'd0,
    C1_READ8           = 3'd1,
    C1_READ16          = 3'd2,
    C1_READ32          = 3'd3,
    C1_INVALIDATE_LINE = 3'd4,
    C1_WRITE8          = 3'd5,
    C1_WRITE16         = 3'd6,
    C1_WRITE32         = 3'd7
  } c1_cmd_e;

  // Same encoding as WRITE32, but seen on the return path.
  localparam logic [2:0] C1_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR1,
    S_ADDR2,
    S_WAIT,
    S_READ_HI,
    S_TURN
  } c1m_state_e;

  function automatic logic is_write(c1_cmd_e cmd);
    return cmd inside {C1_WRITE8, C1_WRITE16, C1_WRITE32};
  endfunction

  function automatic logic is_read(c1_cmd_e cmd);
    return cmd inside {C1_READ8, C1_READ16, C1_READ32};
  endfunction

endpackage

// File: rtl/c1_bus_drv.sv
// Tri-state pads for the C1 data and control buses.
// Each bus floats whenever its output enable is low.
module c1_bus_drv #(
  parameter int WORD_W = 16
) (
  input  logic              data_oe,
  input  logic [WORD_W-1:0] data_val,
  input  logic              ctrl_oe,
  input  logic [2:0]        ctrl_val,
  inout  wire  [WORD_W-1:0] c1_data,
  inout  wire  [2:0]        c1_ctrl
);

  assign c1_data = data_oe ? data_val : 'z;
  assign c1_ctrl = ctrl_oe ? ctrl_val : 'z;

endmodule

// File: rtl/c1_bus_master.sv
// CPU-side C1 bus master: turns one valid/ready request into a full
// C1 transaction with response timeout and error reporting.
module c1_bus_master
  import c1_pkg::*;
#(
  parameter int TAGSET_W    = 10,
  parameter int OFFSET_W    = 4,
  parameter int C1_ADDR_W   = 14,
  parameter int WORD_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_cmd,
  input  logic [TAGSET_W+OFFSET_W-1:0] req_addr,
  input  logic [2*WORD_W-1:0]          req_wdata,
  output logic                         rsp_valid,
  output logic [2*WORD_W-1:0]          rsp_rdata,
  output logic                         rsp_err,
  output logic                         busy,
  output logic [C1_ADDR_W-1:0]         c1_addr,
  inout  wire  [WORD_W-1:0]            c1_data,
  inout  wire  [2:0]                   c1_ctrl
);

  localparam int A_W     = TAGSET_W + OFFSET_W;
  localparam int D_W     = 2 * WORD_W;
  localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  c1m_state_e        state;
  c1_cmd_e           cmd_q;
  c1_cmd_e           cmd_in;
  logic [A_W-1:0]    addr_q;
  logic [D_W-1:0]    wdata_q;
  logic [WORD_W-1:0] lo_q;
  logic [WORD_W-1:0] data_out;
  logic              data_oe;
  logic              ctrl_oe;
  logic [CNT_W-1:0]  cnt;
  logic              rsp_seen;
  logic              timed_out;

  assign cmd_in    = c1_cmd_e'(req_cmd);
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_seen  = (c1_ctrl == C1_RESPONSE);
  assign timed_out = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TO_LAST));

  c1_bus_drv #(.WORD_W(WORD_W)) u_drv (
    .data_oe  (data_oe),
    .data_val (data_out),
    .ctrl_oe  (ctrl_oe),
    .ctrl_val (cmd_q),
    .c1_data  (c1_data),
    .c1_ctrl  (c1_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_q     <= C1_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      ctrl_oe   <= 1'b0;
      cnt       <= '0;
      c1_addr   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            cmd_q   <= cmd_in;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (cmd_in == C1_NOP) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state    <= S_ADDR1;
              ctrl_oe  <= 1'b1;
              data_oe  <= is_write(cmd_in);
              c1_addr  <= C1_ADDR_W'(req_addr[A_W-1:OFFSET_W]);
              data_out <= (cmd_in == C1_WRITE8)
                        ? WORD_W'(req_wdata[7:0])
                        : req_wdata[WORD_W-1:0];
            end
          end
        end
        S_ADDR1: begin
          state   <= S_ADDR2;
          c1_addr <= C1_ADDR_W'(addr_q[OFFSET_W-1:0]);
          if (cmd_q == C1_WRITE32)
            data_out <= wdata_q[D_W-1:WORD_W];
        end
        S_ADDR2: begin
          state   <= S_WAIT;
          ctrl_oe <= 1'b0;
          data_oe <= 1'b0;
          cnt     <= '0;
        end
        S_WAIT: begin
          // A response on the timeout edge still completes normally.
          if (rsp_seen) begin
            if (cmd_q == C1_READ32) begin
              lo_q  <= c1_data;
              state <= S_READ_HI;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              state     <= S_TURN;
              case (cmd_q)
                C1_READ8:  rsp_rdata <= D_W'(c1_data[7:0]);
                C1_READ16: rsp_rdata <= D_W'(c1_data);
                default:   rsp_rdata <= '0;
              endcase
            end
          end else if (timed_out) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= S_TURN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READ_HI: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= {c1_data, lo_q};
          state     <= S_TURN;
        end
        S_TURN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c1_bus_master.sv
// Randomised scoreboard bench for c1_bus_master with a byte-level
// memory reference model and a scripted cache on the C1 bus.
module tb_c1_bus_master;

  localparam int TO = 8;
  localparam logic [2:0] NOP = 3'd0, RD8 = 3'd1, RD16 = 3'd2,
    RD32 = 3'd3, INV = 3'd4, WR8 = 3'd5, WR16 = 3'd6, WR32 = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [13:0] c1_addr;
  wire  [15:0] c1_data;
  wire  [2:0]  c1_ctrl;

  logic        tb_doe, tb_coe;
  logic [15:0] tb_dval;
  logic [2:0]  tb_cval;

  assign c1_data = tb_doe ? tb_dval : 'z;
  assign c1_ctrl = tb_coe ? tb_cval : 'z;

  c1_bus_master #(
    .TAGSET_W(10), .OFFSET_W(4), .C1_ADDR_W(14),
    .WORD_W(16), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .c1_addr(c1_addr), .c1_data(c1_data), .c1_ctrl(c1_ctrl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] ref_mem [int];
  logic [7:0] cache_mem [int];

  int last_acc = 0;
  int exp_gap = 0;
  bit prev_hold = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(int a, int nb);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nb; i++)
      if (ref_mem.exists(a + i)) v[8*i +: 8] = ref_mem[a + i];
    return v;
  endfunction

  function automatic logic [31:0] cache_rd(int a, int nb);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nb; i++)
      if (cache_mem.exists(a + i)) v[8*i +: 8] = cache_mem[a + i];
    return v;
  endfunction

  function automatic void ref_wr(int a, int nb, logic [31:0] d);
    for (int i = 0; i < nb; i++) ref_mem[a + i] = d[8*i +: 8];
  endfunction

  function automatic void cache_wr(int a, int nb, logic [31:0] d);
    for (int i = 0; i < nb; i++) cache_mem[a + i] = d[8*i +: 8];
  endfunction

  function automatic int nbytes(logic [2:0] c);
    case (c)
      RD8, WR8:   return 1;
      RD16, WR16: return 2;
      RD32, WR32: return 4;
      default:    return 0;
    endcase
  endfunction

  // One complete request; n = cache wait cycles before responding.
  task automatic txn(input logic [2:0] cmd, input int addr,
                     input logic [31:0] wd, input int n,
                     input bit hold, input bit stuck, input bit abort);
    exp_t e;
    int acc, k, a;
    bit wr, rd;
    logic [15:0] lo, hi, pat, ew;
    logic [31:0] rv;
    a  = addr;
    wr = (cmd >= WR8);
    rd = (cmd >= RD8) && (cmd <= RD32);
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      errors++;
      checks++;
      $display("FAIL ready_wait: req_ready stuck low, required 1");
      return;
    end
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr[13:0];
    req_wdata = wd;
    @(negedge clk);
    acc = cyc;
    if (prev_hold) check("accept_gap", acc - last_acc, exp_gap);
    prev_hold = 1'b0;
    if (!hold || cmd == NOP || abort) req_valid = 1'b0;

    if (cmd == NOP) begin
      e.rdata = '0; e.err = 1'b1; e.cyc = acc;
      exp_q.push_back(e);
      pat = 16'($urandom);
      tb_doe = 1; tb_dval = pat; tb_coe = 1; tb_cval = 3'd2;
      #1;
      check("nop_data_free", c1_data, pat);
      check("nop_ctrl_free", c1_ctrl, 3'd2);
      check("nop_ready", req_ready, 1'b1);
      tb_doe = 0; tb_coe = 0;
      return;
    end

    rv = '0;
    if (wr) ref_wr(a, nbytes(cmd), wd);
    if (rd) rv = ref_rd(a, nbytes(cmd));
    if (!abort) begin
      e.rdata = stuck ? 32'h0 : rv;
      e.err   = stuck;
      e.cyc   = stuck ? acc + 2 + TO
                      : acc + 3 + n + ((cmd == RD32) ? 1 : 0);
      exp_q.push_back(e);
    end

    // ADDR1
    pat = 16'($urandom);
    if (!wr) begin tb_doe = 1; tb_dval = pat; end
    #1;
    check("a1_ctrl", c1_ctrl, cmd);
    check("a1_addr", c1_addr, 14'(a >> 4));
    check("a1_busy", {busy, req_ready}, 2'b10);
    ew = (cmd == WR8) ? {8'h00, wd[7:0]} : wd[15:0];
    lo = c1_data;
    check("a1_data", c1_data, wr ? ew : pat);
    @(negedge clk);
    // ADDR2
    pat = 16'($urandom);
    if (!wr) tb_dval = pat;
    #1;
    check("a2_ctrl", c1_ctrl, cmd);
    check("a2_addr", c1_addr, 14'(a & 15));
    ew = (cmd == WR32) ? wd[31:16] : ew;
    hi = c1_data;
    check("a2_data", c1_data, wr ? ew : pat);
    if (wr) cache_wr(a, nbytes(cmd), {hi, lo});
    @(negedge clk);

    // WAIT: master must have released both buses
    k = stuck ? TO : (abort ? 1 : n);
    for (int i = 0; i < k; i++) begin
      pat = 16'($urandom);
      tb_doe = 1; tb_dval = pat; tb_coe = 1; tb_cval = 3'd0;
      #1;
      check("wait_data_free", c1_data, pat);
      check("wait_ctrl_free", c1_ctrl, 3'd0);
      if (abort) begin
        reset = 1'b1;
        req_valid = 1'b0;
      end
      @(negedge clk);
    end

    if (abort) begin
      reset = 1'b0;
      pat = 16'($urandom);
      tb_dval = pat; tb_cval = 3'd1;
      #1;
      check("abort_ready", req_ready, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_no_rsp", rsp_valid, 1'b0);
      check("abort_data_free", c1_data, pat);
      check("abort_ctrl_free", c1_ctrl, 3'd1);
      tb_doe = 0; tb_coe = 0;
      return;
    end

    if (!stuck) begin
      tb_doe = 1; tb_coe = 1; tb_cval = 3'd7;
      case (cmd)
        RD8:     tb_dval = {8'($urandom), cache_rd(a, 1)[7:0]};
        RD16:    tb_dval = cache_rd(a, 2)[15:0];
        RD32:    tb_dval = cache_rd(a, 2)[15:0];
        default: tb_dval = 16'($urandom);
      endcase
      @(negedge clk);
      if (cmd == RD32) begin
        tb_coe  = 0;
        tb_dval = cache_rd(a + 2, 2)[15:0];
        @(negedge clk);
      end
    end
    tb_doe = 0; tb_coe = 0;
    last_acc  = acc;
    prev_hold = hold;
    exp_gap   = stuck ? TO + 4 : 5 + n + ((cmd == RD32) ? 1 : 0);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, required 0",
                   cyc);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", cyc, e.cyc);
          check("rsp_err", rsp_err, e.err);
          check("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    logic [2:0] c;
    int n;
    reset = 1; req_valid = 0; req_cmd = 0; req_addr = 0;
    req_wdata = 0; tb_doe = 0; tb_coe = 0; tb_dval = 0; tb_cval = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_c1_addr", c1_addr, 14'h0);
    reset = 0;
    @(negedge clk);

    txn(WR8,  'h000, 32'h0000aa11, 2, 0, 0, 0);
    txn(WR32, 'h000, 32'h33334444, 1, 0, 0, 0);
    txn(RD32, 'h000, 32'h0,        3, 0, 0, 0);
    txn(WR16, 'h004, 32'h00002222, 0, 0, 0, 0);
    txn(RD8,  'h004, 32'h0,        0, 0, 0, 0);
    txn(RD16, 'h004, 32'h0,        1, 0, 0, 0);
    txn(RD8,  'h004, 32'h0,        0, 1, 1, 0);
    txn(RD16, 'h004, 32'h0,        0, 0, 0, 0);
    txn(INV,  'h080, 32'h0,        2, 0, 0, 0);
    txn(INV,  'h3f0, 32'h0,        0, 0, 0, 0);
    txn(NOP,  'h004, 32'h0,        0, 0, 0, 0);
    txn(RD8,  'h004, 32'h0,        3, 0, 0, 1);
    txn(RD8,  'h004, 32'h0,        0, 1, 0, 0);
    txn(RD8,  'h000, 32'h0,        2, 1, 0, 0);
    txn(RD8,  'h005, 32'h0,        4, 1, 0, 0);
    txn(RD16, 'h004, 32'h0,        TO - 1, 0, 0, 0);

    for (int t = 0; t < 120; t++) begin
      c = 3'($urandom_range(0, 7));
      n = $urandom_range(0, TO - 1);
      txn(c, ($urandom_range(0, 3) << 4) | $urandom_range(0, 15),
          $urandom, n, 1'($urandom_range(0, 1)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 24) == 0);
    end

    req_valid = 0;
    repeat (6) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
